// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The entry struct here uses the default 32-bit widths; fetch_unit builds its own entry type from its parameters.
package fetch_pkg;

  localparam int INSTR_BYTES      = 4;
  localparam int FETCH_ADDR_WIDTH = 32;
  localparam int FETCH_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Instruction targets must sit on a word boundary.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO of fetch entries with flush and async reset.
// The head reads as all-zero while the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_flush,
  input  entry_t i_wr_data,
  output entry_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;

  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_head = o_empty ? entry_t'('0) : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, buffers fetched words
// and hands {pc, instr} to decode; handles redirects, end-of-program halt and misaligned-target faults.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    PROGRAM_LENGTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    FIFO_DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  halted_o,
  output logic                  fault_o,
  output logic [ADDR_WIDTH-1:0] fault_pc_o,
  output fetch_state_e          state_o
);

  // Handshake to decode: the head entry transfers on a rising edge where
  // valid_o && ready_i; valid_o never depends on ready_i, and once raised it
  // stays up with stable data until accepted or flushed by a redirect.

  localparam int                    WORD_W     = ADDR_WIDTH - 2;
  localparam logic [WORD_W-1:0]     PROG_WORDS = WORD_W'(PROGRAM_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] r_pc;
  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_fault_pc;

  logic   w_in_range;
  logic   w_full;
  logic   w_empty;
  logic   w_pop;
  logic   w_push;
  entry_t w_wr_entry;
  entry_t w_head;

  assign w_in_range = (r_pc[ADDR_WIDTH-1:2] < PROG_WORDS);
  assign w_pop      = !w_empty && ready_i;
  assign w_push     = (r_state == RUN) && !redirect_i && w_in_range && (!w_full || w_pop);
  assign w_wr_entry = '{pc: r_pc, instr: instruction_i};

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (redirect_i),
    .i_wr_data (w_wr_entry),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Redirect outranks every state; a misaligned target parks the PC and faults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_state    <= RUN;
      r_fault_pc <= '0;
    end else if (redirect_i) begin
      if (is_aligned(redirect_pc_i[1:0])) begin
        r_pc    <= redirect_pc_i;
        r_state <= RUN;
      end else begin
        r_state    <= FAULT;
        r_fault_pc <= redirect_pc_i;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (!w_in_range)  r_state <= HALT;
          else if (w_push)  r_pc    <= r_pc + PC_STEP;
        end
        HALT:    r_state <= HALT;
        FAULT:   r_state <= FAULT;
        default: r_state <= RUN;
      endcase
    end
  end

  assign read_address_o = r_pc;
  assign valid_o        = !w_empty;
  assign instr_o        = w_head.instr;
  assign pc_o           = w_head.pc;
  assign halted_o       = (r_state == HALT) && w_empty;
  assign fault_o        = (r_state == FAULT);
  assign fault_pc_o     = r_fault_pc;
  assign state_o        = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, halt, redirect,
// fault recovery and asynchronous reset mid-stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] read_address_o;
  logic [31:0] instruction_i;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halted_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;
  fetch_state_e state_o;

  logic [63:0] exp_q[$];
  logic [31:0] mem [0:15];
  int          total = 0;
  int          bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .PROGRAM_LENGTH (10),
    .RESET_PC       (32'h0),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .read_address_o (read_address_o),
    .instruction_i  (instruction_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .halted_o       (halted_o),
    .fault_o        (fault_o),
    .fault_pc_o     (fault_pc_o),
    .state_o        (state_o)
  );

  function automatic logic [31:0] prog_word(input int idx);
    return 32'h0000_0013 + (32'(idx) << 20);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? prog_word(i) : 32'hDEAD_0000;
  end

  assign instruction_i = mem[read_address_o[5:2]];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    ready_i    = rdy;
    redirect_i = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_words(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back({32'(i * 4), prog_word(i)});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},    64'(valid_o),        64'd0);
    check({tag, "_addr"},     64'(read_address_o), 64'd0);
    check({tag, "_pc_o"},     64'(pc_o),           64'd0);
    check({tag, "_instr_o"},  64'(instr_o),        64'd0);
    check({tag, "_halted"},   64'(halted_o),       64'd0);
    check({tag, "_fault"},    64'(fault_o),        64'd0);
    check({tag, "_fault_pc"}, 64'(fault_pc_o),     64'd0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_queue_left"}, 64'(exp_q.size()),   64'd0);
    check({tag, "_valid"},      64'(valid_o),        64'd0);
    check({tag, "_halted"},     64'(halted_o),       64'd1);
    check({tag, "_addr"},       64'(read_address_o), 64'h28);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i && !redirect_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%0h instr=%0h want nothing", pc_o, instr_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({pc_o, instr_o} !== e) begin
          bad++;
          $display("FAIL sb_entry: got pc=%0h instr=%0h want pc=%0h instr=%0h",
                   pc_o, instr_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // streaming straight into halt
    do_reset(1'b1);
    check_reset_state("rst");
    expect_words(0, 9);
    tick();
    check("stream_first_valid", 64'(valid_o), 64'd1);
    check("stream_first_pc",    64'(pc_o),    64'd0);
    repeat (10) tick();
    check_drained("stream_end");

    // backpressure
    do_reset(1'b0);
    repeat (5) tick();
    check("bp_valid",     64'(valid_o),        64'd1);
    check("bp_head_pc",   64'(pc_o),           64'd0);
    check("bp_head_ins",  64'(instr_o),        64'(prog_word(0)));
    check("bp_addr_hold", 64'(read_address_o), 64'h8);
    expect_words(0, 9);
    ready_i = 1'b1;
    repeat (14) tick();
    check_drained("bp_end");

    // redirect with two buffered entries and a pop pending
    do_reset(1'b0);
    repeat (3) tick();
    check("rd_full_head", 64'(pc_o), 64'd0);
    ready_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h10;
    tick();
    redirect_i = 1'b0;
    check("rd_valid_flushed", 64'(valid_o),        64'd0);
    check("rd_addr",          64'(read_address_o), 64'h10);
    expect_words(4, 9);
    tick();
    check("rd_target_valid", 64'(valid_o), 64'd1);
    check("rd_target_pc",    64'(pc_o),    64'h10);
    repeat (8) tick();
    check_drained("rd_end");

    // misaligned redirect faults, aligned redirect recovers
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h6;
    tick();
    redirect_i = 1'b0;
    check("flt_fault",    64'(fault_o),        64'd1);
    check("flt_fault_pc", 64'(fault_pc_o),     64'h6);
    check("flt_halted",   64'(halted_o),       64'd0);
    check("flt_addr",     64'(read_address_o), 64'h28);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("flt_hold_valid", 64'(valid_o), 64'd0);
      check("flt_hold_fault", 64'(fault_o), 64'd1);
    end
    expect_words(2, 9);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8;
    tick();
    redirect_i = 1'b0;
    check("rec_fault", 64'(fault_o),        64'd0);
    check("rec_valid", 64'(valid_o),        64'd0);
    check("rec_addr",  64'(read_address_o), 64'h8);
    tick();
    check("rec_valid2", 64'(valid_o), 64'd1);
    check("rec_pc",     64'(pc_o),    64'h8);
    repeat (10) tick();
    check_drained("rec_end");

    // asynchronous reset with entries buffered
    do_reset(1'b0);
    repeat (3) tick();
    check("mid_buffered", 64'(valid_o), 64'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_valid", 64'(valid_o),        64'd0);
    check("mid_addr",  64'(read_address_o), 64'd0);
    check("mid_pc_o",  64'(pc_o),           64'd0);
    tick();
    tick();
    ready_i = 1'b1;
    rst     = 1'b0;
    check_reset_state("mid_rel");
    expect_words(0, 9);
    tick();
    check("mid_restart_pc", 64'(pc_o), 64'd0);
    repeat (10) tick();
    check_drained("mid_end");

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage directly upstream of instruction memory.
- Owns the program counter and drives the memory read address.
- Captures the asynchronously-read instruction word into a small prefetch FIFO and presents {pc, instruction} to decode over a valid/ready handshake.
- Handles branch/jump redirects, end-of-program halt and misaligned-target faults.

Parameters:
- ADDR_WIDTH, 32: PC/address width.
- DATA_WIDTH, 32: instruction width.
- PROGRAM_LENGTH, 10: program size in words; fetch beyond this halts.
- RESET_PC, 0: PC value after reset.
- FIFO_DEPTH, 2: prefetch entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_address_o  out  ADDR_WIDTH  address to instruction memory; equals pc_q.
- instruction_i  in  DATA_WIDTH  async-read instruction word for read_address_o.
- valid_o  out  1  head entry valid to decode.
- ready_i  in  1  decode accepts the head entry.
- instr_o  out  DATA_WIDTH  head instruction.
- pc_o  out  ADDR_WIDTH  head PC.
- redirect_i  in  1  branch/jump taken; flush and retarget.
- redirect_pc_i  in  ADDR_WIDTH  redirect target.
- halted_o  out  1  state HALT and FIFO empty.
- fault_o  out  1  state FAULT.
- fault_pc_o  out  ADDR_WIDTH  offending redirect target, held while in FAULT.

Behaviour:
- Reset (async assert, sync use on release):
  - pc_q = RESET_PC; FIFO empty; state RUN.
  - valid_o = 0, halted_o = 0, fault_o = 0, fault_pc_o = 0.
  - instr_o and pc_o read as 0 when the FIFO is empty.
- States: RUN, HALT, FAULT.
- Pop: valid_o && ready_i removes the head at the clock edge.
- Push (RUN only): occurs when all of the following hold:
  - no redirect_i this cycle;
  - pc_q[ADDR_WIDTH-1:2] < PROGRAM_LENGTH;
  - FIFO not full, or full with a pop in the same cycle.
  - Effect: writes {pc_q, instruction_i} and sets pc_q <= pc_q + 4. Addition wraps modulo 2^ADDR_WIDTH.
- Latency and throughput: an instruction is visible on valid_o one cycle after its address is presented. With ready_i held high, throughput is one instruction per cycle and the first valid_o is in the 2nd cycle after reset release.
- Full with no pop: no push and pc_q holds. read_address_o stays stable and is re-read next cycle.
- End of program: in RUN, pc_q word index >= PROGRAM_LENGTH with no redirect moves the state to HALT. No push occurs and pc_q holds. Already-buffered entries still drain to decode; halted_o rises once the FIFO is empty.
- Redirect (highest priority, any state):
  - FIFO flushed (count = 0); any simultaneous pop and push are discarded; valid_o = 0 next cycle.
  - If redirect_pc_i[1:0] == 0: pc_q <= redirect_pc_i and state <= RUN. This also exits HALT and FAULT.
  - Else: state <= FAULT, fault_pc_o <= redirect_pc_i, and pc_q holds.
- FAULT: no push and valid_o = 0. The block stays in FAULT until an aligned redirect or reset.
- Reset mid-operation: immediate return to reset values; FIFO contents are discarded.
- FIFO implementation: read and write pointers of log2(FIFO_DEPTH) bits wrap naturally, plus a count of log2(FIFO_DEPTH)+1 bits. Full means count == FIFO_DEPTH; empty means count == 0.
- No combinational path from ready_i to read_address_o. valid_o, instr_o and pc_o are driven from registers and FIFO storage only.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_e enum {RUN, HALT, FAULT};
  - fetch_entry_t struct {pc, instr};
  - constant INSTR_BYTES = 4.
- One natural sub-module: fetch_fifo. It is a parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and head outputs, and asynchronous reset.
- fetch_unit instantiates fetch_fifo and contains the PC register, state machine and redirect logic.

Test Plan:
- Setup for all scenarios: memory model words 0..9 = 0x00000013 + (i << 20).
- Streaming: reset release with ready_i = 1 -> valid_o first high in cycle 2, pc_o sequence 0x0, 0x4, ..., 0x24 on consecutive cycles, instr_o matches the model.
- Backpressure: ready_i = 0 for 5 cycles after reset -> FIFO fills with pc 0x0 and 0x4, read_address_o holds 0x8. Then ready_i = 1 -> 0x0, 0x4, 0x8 delivered in order with no drop or duplicate.
- Halt: run to the end -> after pc_o = 0x24 is accepted, valid_o = 0, halted_o = 1, read_address_o holds 0x28.
- Redirect: redirect_i = 1 with redirect_pc_i = 0x10 while the FIFO holds 2 entries and a pop is asserted -> next cycle valid_o = 0 and read_address_o = 0x10. The following cycle pc_o = 0x10.
- Fault and recovery:
  - redirect_pc_i = 0x0000_0006 -> fault_o = 1, fault_pc_o = 0x6, valid_o stays 0 for 10 cycles.
  - Then redirect to 0x8 -> fault_o = 0 and pc_o = 0x8 two cycles later.
- Reset mid-stream: assert rst between clock edges with 2 entries buffered -> valid_o = 0 and read_address_o = 0x0 immediately. After release, streaming restarts from 0x0.
